// File: rtl/intr_pkg.sv
// Shared types and constants for the machine-mode interrupt sequencer:
// FSM states, mcause exception codes and mtvec mode encodings.
package intr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_TRAP = 2'd2,
        ST_MRET = 2'd3
    } state_e;

    localparam logic [3:0] MCAUSE_MEI = 4'd11;
    localparam logic [3:0] MCAUSE_MTI = 4'd7;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

endpackage

// File: rtl/intr_ctrl.sv
// Machine-mode interrupt and mret sequencer: latches timer/external requests,
// waits for a valid unstalled D-stage instruction, then issues trap entry or return.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          t_intr_i,
    input  logic          e_intr_i,
    input  logic          mstatus_mie_i,
    input  logic          mie_mtie_i,
    input  logic          mie_meie_i,
    input  logic [DW-1:0] mtvec_i,
    input  logic [DW-1:0] mepc_i,
    input  logic [DW-1:0] pc_d_i,
    input  logic          valid_d_i,
    input  logic          stall_i,
    input  logic          mret_i,
    output logic          mip_mtip_o,
    output logic          mip_meip_o,
    output logic          flush_o,
    output logic          redirect_o,
    output logic [DW-1:0] redirect_pc_o,
    output logic          mepc_we_o,
    output logic [DW-1:0] mepc_wdata_o,
    output logic          mcause_we_o,
    output logic [DW-1:0] mcause_wdata_o,
    output logic          trap_enter_o,
    output logic          trap_ret_o
);

    state_e        state_q, state_d;
    logic          mtip_q, mtip_d;
    logic          meip_q, meip_d;
    logic [3:0]    cause_q, cause_d;
    logic [DW-1:0] epc_q, epc_d;

    logic          en_e, en_t;
    logic [DW-1:0] trap_base, trap_target;

    assign en_e = meip_q & mie_meie_i & mstatus_mie_i;
    assign en_t = mtip_q & mie_mtie_i & mstatus_mie_i;

    // Pending latches: cleared in the TRAP cycle of their own source; a new request wins.
    always_comb begin
        mtip_d = mtip_q;
        meip_d = meip_q;
        if (state_q == ST_TRAP) begin
            if (cause_q == MCAUSE_MTI) begin
                mtip_d = 1'b0;
            end else begin
                meip_d = 1'b0;
            end
        end else begin
            mtip_d = mtip_q;
        end
        mtip_d = mtip_d | t_intr_i;
        meip_d = meip_d | e_intr_i;
    end

    // Next-state logic; cause and PC are captured on the WAIT->TRAP transition.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        case (state_q)
            ST_IDLE: begin
                if (mret_i) begin
                    state_d = ST_MRET;
                end else if (en_e | en_t) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mret_i) begin
                    state_d = ST_MRET;
                end else if (!(en_e | en_t)) begin
                    state_d = ST_IDLE;
                end else if (!stall_i && valid_d_i) begin
                    state_d = ST_TRAP;
                    cause_d = en_e ? MCAUSE_MEI : MCAUSE_MTI;
                    epc_d   = pc_d_i;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_TRAP: state_d = ST_IDLE;
            ST_MRET: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pending and latched-cause registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            mtip_q  <= 1'b0;
            meip_q  <= 1'b0;
            cause_q <= 4'd0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            mtip_q  <= mtip_d;
            meip_q  <= meip_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    // Vectored mode offsets the base by 4*code; all other modes jump to the base.
    always_comb begin
        trap_base = {mtvec_i[DW-1:2], 2'b00};
        if (mtvec_i[1:0] == MTVEC_VECTORED) begin
            trap_target = trap_base + {{(DW-6){1'b0}}, cause_q, 2'b00};
        end else begin
            trap_target = trap_base;
        end
    end

    // Moore output decode: only TRAP and MRET drive anything.
    always_comb begin
        flush_o        = 1'b0;
        redirect_o     = 1'b0;
        redirect_pc_o  = '0;
        mepc_we_o      = 1'b0;
        mepc_wdata_o   = '0;
        mcause_we_o    = 1'b0;
        mcause_wdata_o = '0;
        trap_enter_o   = 1'b0;
        trap_ret_o     = 1'b0;
        case (state_q)
            ST_TRAP: begin
                flush_o        = 1'b1;
                redirect_o     = 1'b1;
                redirect_pc_o  = trap_target;
                mepc_we_o      = 1'b1;
                mepc_wdata_o   = epc_q;
                mcause_we_o    = 1'b1;
                mcause_wdata_o = {1'b1, {(DW-5){1'b0}}, cause_q};
                trap_enter_o   = 1'b1;
            end
            ST_MRET: begin
                flush_o        = 1'b1;
                redirect_o     = 1'b1;
                redirect_pc_o  = mepc_i;
                trap_ret_o     = 1'b1;
            end
            default: begin
                flush_o        = 1'b0;
            end
        endcase
    end

    assign mip_mtip_o = mtip_q;
    assign mip_meip_o = meip_q;

endmodule
